bcd_seq_addsub: RTL

- Parametrised, digit-serial packed-BCD adder/subtractor for DIGITS-digit operands.
- Processes one decimal digit per clock, LSD first. Subtraction is done by ten's complement with automatic recomplement, so the result is returned as sign plus magnitude.
- Validates operand digits and sits behind valid/ready handshakes on both sides, for use in the arithmetic datapath.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 26 ++
 rtl/bcd_seq_addsub.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD    = 2'd1,
      RECOMP = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
      return BCD_MAX_DIGIT - d;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with carry; shared by the add and recomplement phases.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t sum,
   output logic       cout
);

   logic [4:0] raw;
   logic [4:0] adj;

   always_comb begin
      raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      adj  = raw + 5'd6;
      sum  = raw[3:0];
      cout = 1'b0;
      if (raw > 5'd9) begin
         sum  = adj[3:0];
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_seq_addsub.sv
// Digit-serial packed-BCD add/subtract, LSD first, sign-magnitude result.
//
//   state  | meaning
//   IDLE   | ready for a new operation
//   ADD    | A + B (or A + 9's(B) + 1), one digit per cycle
//   RECOMP | negative difference: ten's-complement the partial result
//   DONE   | result and flags presented until out_ready
module bcd_seq_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] op_a,
   input  logic [4*DIGITS-1:0] op_b,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] result,
   output logic                negative,
   output logic                overflow,
   output logic                error
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                carry_q, carry_d;
   logic                sub_q, sub_d;
   logic [4*DIGITS-1:0] a_q, a_d;
   logic [4*DIGITS-1:0] b_q, b_d;
   logic [4*DIGITS-1:0] result_q, result_d;
   logic                negative_q, negative_d;
   logic                overflow_q, overflow_d;
   logic                error_q, error_d;

   bcd_digit_t add_a, add_b, add_sum;
   logic       add_cin, add_cout;
   bcd_digit_t a_dig, b_dig, r_dig;
   logic       bad_digit;

   bcd_digit_add u_digit_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign a_dig = a_q[4*idx_q +: 4];
   assign b_dig = b_q[4*idx_q +: 4];
   assign r_dig = result_q[4*idx_q +: 4];

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (op_a[4*i +: 4] > BCD_MAX_DIGIT || op_b[4*i +: 4] > BCD_MAX_DIGIT)
            bad_digit = 1'b1;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign negative  = negative_q;
   assign overflow  = overflow_q;
   assign error     = error_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      sub_d      = sub_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      negative_d = negative_q;
      overflow_d = overflow_q;
      error_d    = error_q;
      add_a      = '0;
      add_b      = '0;
      add_cin    = carry_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d        = op_a;
               b_d        = op_b;
               sub_d      = sub;
               idx_d      = '0;
               result_d   = '0;
               negative_d = 1'b0;
               overflow_d = 1'b0;
               error_d    = bad_digit;
               carry_d    = sub;
               state_d    = bad_digit ? DONE : ADD;
            end
         end
         ADD: begin
            add_a = a_dig;
            add_b = sub_q ? nines_comp(b_dig) : b_dig;
            result_d[4*idx_q +: 4] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (!sub_q) begin
                  overflow_d = add_cout;
                  state_d    = DONE;
               end else if (add_cout) begin
                  state_d = DONE;
               end else begin
                  // No end-around carry: A < B, so recomplement to get |A-B|
                  carry_d = 1'b1;
                  state_d = RECOMP;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         RECOMP: begin
            add_b = nines_comp(r_dig);
            result_d[4*idx_q +: 4] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               idx_d      = '0;
               negative_d = 1'b1;
               state_d    = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         sub_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         sub_q      <= sub_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         negative_q <= negative_d;
         overflow_q <= overflow_d;
         error_q    <= error_d;
      end
   end

endmodule
